// File: rtl/nios2_onchip_ram_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slave ports, byte lanes, 1/2-cycle read latency.
// Optional per-byte even parity storage and checking: define NIOS2_ONCHIP_RAM_PARITY_EN.
module nios2_onchip_ram_dp #(
  parameter string INIT_FILE    = "nios2_onchip_ram_dp.hex",
  parameter int    DATA_W       = 32,
  parameter int    DEPTH        = 5120,
  parameter int    ADDR_W       = 13,
  parameter int    READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                reset_req,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                addr_err
`ifdef NIOS2_ONCHIP_RAM_PARITY_EN
  ,
  output logic                s1_parity_err,
  output logic                s2_parity_err
`endif
);

  localparam int BE_W = DATA_W / 8;

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (longint'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
    $error("DEPTH exceeds the ADDR_W address space");
  end
  if (INIT_FILE == "") begin : g_bad_init
    $error("INIT_FILE must name the preload image");
  end

  // Preload comes from the device configuration image named by INIT_FILE.
  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        cs, rd, wr;
  logic [ADDR_W-1:0] addr  [2];
  logic [BE_W-1:0]   be    [2];
  logic [DATA_W-1:0] wdata [2];

  assign cs       = {s2_chipselect, s1_chipselect};
  assign rd       = {s2_read, s1_read};
  assign wr       = {s2_write, s1_write};
  assign addr[0]  = s1_address;
  assign addr[1]  = s2_address;
  assign be[0]    = s1_byteenable;
  assign be[1]    = s2_byteenable;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;

  logic [1:0] acc, acc_wr, acc_rd, in_range;

  always_comb begin
    acc      = '0;
    acc_wr   = '0;
    acc_rd   = '0;
    in_range = '0;
    for (int p = 0; p < 2; p++) begin
      acc[p]      = cs[p] & (rd[p] | wr[p]) & clken & ~reset_req & ~reset;
      acc_wr[p]   = acc[p] & wr[p];
      acc_rd[p]   = acc[p] & rd[p] & ~wr[p];
      in_range[p] = 32'(addr[p]) < 32'(DEPTH);
    end
  end

`ifdef NIOS2_ONCHIP_RAM_PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];
  logic [1:0]      pe1, pe2, peo, pe_last;

  function automatic logic [BE_W-1:0] lane_par(input logic [DATA_W-1:0] d);
    lane_par = '0;
    for (int b = 0; b < BE_W; b++) lane_par[b] = ^d[b*8 +: 8];
  endfunction

  assign pe_last       = (READ_LATENCY == 2) ? pe2 : pe1;
  assign s1_parity_err = peo[0];
  assign s2_parity_err = peo[1];
`endif

  // s2 is applied first so s1 overrides it on lanes both ports enable.
  always_ff @(posedge clk) begin
    for (int p = 1; p >= 0; p--) begin
      if (acc_wr[p] && in_range[p]) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[p][b]) begin
            mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
`ifdef NIOS2_ONCHIP_RAM_PARITY_EN
            par_mem[addr[p]][b] <= ^wdata[p][b*8 +: 8];
`endif
          end
        end
      end
    end
  end

  // readdatavalid is a single-cycle qualifier for readdata; with clken low the
  // whole pipeline freezes, so a pending valid is held until clken returns.
  logic [1:0]        v1, v2, vo, v_last;
  logic [DATA_W-1:0] d1 [2];
  logic [DATA_W-1:0] d2 [2];
  logic [DATA_W-1:0] dout [2];
  logic [DATA_W-1:0] d_last [2];

  always_comb begin
    v_last = (READ_LATENCY == 2) ? v2 : v1;
    for (int p = 0; p < 2; p++) d_last[p] = (READ_LATENCY == 2) ? d2[p] : d1[p];
  end

  // Stage 1 samples the array before this edge's writes land, giving old data
  // on a cross-port collision and new data for a following-cycle read.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= '0;
      v2      <= '0;
      vo      <= '0;
      dout[0] <= '0;
      dout[1] <= '0;
`ifdef NIOS2_ONCHIP_RAM_PARITY_EN
      pe1 <= '0;
      pe2 <= '0;
      peo <= '0;
`endif
    end else if (clken) begin
      for (int p = 0; p < 2; p++) begin
        v1[p] <= acc_rd[p];
        d1[p] <= in_range[p] ? mem[addr[p]] : '0;
        v2[p] <= v1[p];
        if (v1[p]) d2[p] <= d1[p];
        vo[p] <= v_last[p];
        if (v_last[p]) dout[p] <= d_last[p];
`ifdef NIOS2_ONCHIP_RAM_PARITY_EN
        pe1[p] <= in_range[p] && (lane_par(mem[addr[p]]) != par_mem[addr[p]]);
        pe2[p] <= pe1[p];
        peo[p] <= v_last[p] & pe_last[p];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) addr_err <= 1'b0;
    else if (|(acc & ~in_range)) addr_err <= 1'b1;
  end

  assign s1_readdata      = dout[0];
  assign s2_readdata      = dout[1];
  assign s1_readdatavalid = vo[0];
  assign s2_readdatavalid = vo[1];

endmodule

// File: tb/tb_nios2_onchip_ram_dp.sv
// Bench for nios2_onchip_ram_dp: latency-1 and latency-2 instances share stimulus,
// each port/instance has its own expected queue of read data and enabled-cycle arrival time.
module tb_nios2_onchip_ram_dp;

  logic        clk = 1'b0;
  logic        reset, clken, reset_req;
  logic        s1_chipselect, s1_read, s1_write;
  logic [12:0] s1_address;
  logic [3:0]  s1_byteenable;
  logic [31:0] s1_writedata;
  logic        s2_chipselect, s2_read, s2_write;
  logic [12:0] s2_address;
  logic [3:0]  s2_byteenable;
  logic [31:0] s2_writedata;

  logic [31:0] a_s1_rdata, a_s2_rdata, b_s1_rdata, b_s2_rdata;
  logic        a_s1_rvld, a_s2_rvld, b_s1_rvld, b_s2_rvld;
  logic        a_aerr, b_aerr;
`ifdef NIOS2_ONCHIP_RAM_PARITY_EN
  logic        a_p1, a_p2, b_p1, b_p2;
`endif

  logic [31:0] rdat [4];
  logic        rvld [4];
  logic [31:0] exp_q   [4][$];
  logic [31:0] exp_t_q [4][$];

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  bit last_en = 1'b0;

  always #5 clk = ~clk;

  nios2_onchip_ram_dp #(.READ_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(a_s1_rdata), .s1_readdatavalid(a_s1_rvld),
    .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(a_s2_rdata), .s2_readdatavalid(a_s2_rvld),
    .addr_err(a_aerr)
`ifdef NIOS2_ONCHIP_RAM_PARITY_EN
    , .s1_parity_err(a_p1), .s2_parity_err(a_p2)
`endif
  );

  nios2_onchip_ram_dp #(.READ_LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(b_s1_rdata), .s1_readdatavalid(b_s1_rvld),
    .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(b_s2_rdata), .s2_readdatavalid(b_s2_rvld),
    .addr_err(b_aerr)
`ifdef NIOS2_ONCHIP_RAM_PARITY_EN
    , .s1_parity_err(b_p1), .s2_parity_err(b_p2)
`endif
  );

  always_comb begin
    rdat[0] = a_s1_rdata; rdat[1] = a_s2_rdata; rdat[2] = b_s1_rdata; rdat[3] = b_s2_rdata;
    rvld[0] = a_s1_rvld;  rvld[1] = a_s2_rvld;  rvld[2] = b_s1_rvld;  rvld[3] = b_s2_rvld;
  end

  // Count edges on which the block actually advances.
  always @(posedge clk) begin
    last_en = clken && !reset;
    if (last_en) en_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a fresh output word exists only after an enabled edge.
  logic [31:0] mon_d, mon_t;
  always @(negedge clk) begin
    if (last_en) begin
      for (int i = 0; i < 4; i++) begin
        if (rvld[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid ch%0d: got data %h expected no valid", i, rdat[i]);
          end else begin
            mon_d = exp_q[i].pop_front();
            mon_t = exp_t_q[i].pop_front();
            chk($sformatf("rd_data ch%0d", i), rdat[i], mon_d);
            chk($sformatf("rd_time ch%0d", i), 32'(en_cnt), mon_t);
          end
        end
      end
    end
  end

  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_wr(input int p, input logic [12:0] a, input logic [31:0] d, input logic [3:0] b);
    if (p == 0) begin
      s1_chipselect = 1; s1_write = 1; s1_address = a; s1_writedata = d; s1_byteenable = b;
    end else begin
      s2_chipselect = 1; s2_write = 1; s2_address = a; s2_writedata = d; s2_byteenable = b;
    end
  endtask

  // Expected arrival assumes the read is accepted on the next edge.
  task automatic set_rd(input int p, input logic [12:0] a, input logic [31:0] d, input bit push);
    if (p == 0) begin
      s1_chipselect = 1; s1_read = 1; s1_address = a;
    end else begin
      s2_chipselect = 1; s2_read = 1; s2_address = a;
    end
    if (push) begin
      exp_q[p].push_back(d);
      exp_t_q[p].push_back(32'(en_cnt + 2));
      exp_q[2+p].push_back(d);
      exp_t_q[2+p].push_back(32'(en_cnt + 3));
    end
  endtask

  function automatic bit queues_empty();
    queues_empty = 1'b1;
    for (int i = 0; i < 4; i++) if (exp_q[i].size() != 0) queues_empty = 1'b0;
  endfunction

  initial begin
    reset = 1; clken = 1; reset_req = 0;
    s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
    s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
    idle();
    repeat (3) cycle();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_rdata ch%0d", i), rdat[i], 32'h0);
      chk($sformatf("reset_rvld ch%0d", i), 32'(rvld[i]), 32'h0);
    end
    chk("reset_addr_err_l1", 32'(a_aerr), 32'h0);
    chk("reset_addr_err_l2", 32'(b_aerr), 32'h0);
    reset = 0;
    cycle();

    // Basic write then read, and same-port read-after-write.
    set_wr(0, 13'h10, 32'hDEADBEEF, 4'hF); cycle();
    set_rd(0, 13'h10, 32'hDEADBEEF, 1);    cycle();
    set_wr(0, 13'h20, 32'h12345678, 4'hF); cycle();
    set_rd(0, 13'h20, 32'h12345678, 1);    cycle();

    // Byte lanes.
    set_wr(0, 13'd5, 32'h11223344, 4'hF); cycle();
    set_wr(0, 13'd5, 32'hAABBCCDD, 4'h5); cycle();
    set_rd(1, 13'd5, 32'h11BB33DD, 1);    cycle();

    // Back-to-back reads with a 3-cycle clock-enable stall mid-stream.
    set_wr(1, 13'd0, 32'hA0000000, 4'hF); cycle();
    set_wr(1, 13'd1, 32'hA1111111, 4'hF); cycle();
    set_wr(1, 13'd2, 32'hA2222222, 4'hF); cycle();
    set_rd(0, 13'd0, 32'hA0000000, 1); set_rd(1, 13'd2, 32'hA2222222, 1); cycle();
    set_rd(0, 13'd1, 32'hA1111111, 1); cycle();
    clken = 0;
    set_wr(1, 13'd2, 32'h0, 4'hF);
    repeat (3) cycle();
    clken = 1;
    set_rd(0, 13'd2, 32'hA2222222, 1); cycle();

    // Collisions: dual write merge, then mixed-port read returns old data.
    set_wr(0, 13'd7, 32'hFFFF0000, 4'hC); set_wr(1, 13'd7, 32'h0000FFFF, 4'hF); cycle();
    set_rd(1, 13'd7, 32'hFFFFFFFF, 1);    set_wr(0, 13'd7, 32'h0, 4'hF);        cycle();
    set_rd(0, 13'd7, 32'h00000000, 1);    cycle();
    set_wr(0, 13'd8, 32'h11111111, 4'hF); set_wr(1, 13'd8, 32'h22222222, 4'h3); cycle();
    set_wr(0, 13'd9, 32'h00000000, 4'hF); cycle();
    set_wr(0, 13'd9, 32'h000000AA, 4'h1); set_wr(1, 13'd9, 32'hBBBBBBBB, 4'h3); cycle();
    set_rd(0, 13'd8, 32'h11111111, 1);    set_rd(1, 13'd9, 32'h0000BBAA, 1);    cycle();

    // Read and write together on one port: write only, no valid.
    set_wr(0, 13'h30, 32'h00000055, 4'hF); set_rd(0, 13'h30, 32'h0, 0); cycle();
    set_rd(0, 13'h30, 32'h00000055, 1);    cycle();

    // reset_req blocks new transfers but lets the in-flight read finish.
    set_rd(0, 13'h10, 32'hDEADBEEF, 1); cycle();
    reset_req = 1;
    set_wr(0, 13'h10, 32'h0, 4'hF); set_rd(1, 13'd5, 32'h0, 0);
    repeat (3) cycle();
    reset_req = 0;
    set_rd(0, 13'h10, 32'hDEADBEEF, 1); cycle();

    // Last word and out-of-range accesses.
    set_wr(1, 13'd5119, 32'hCAFEF00D, 4'hF); cycle();
    set_rd(1, 13'd5119, 32'hCAFEF00D, 1);    cycle();
    chk("addr_err_in_range_l1", 32'(a_aerr), 32'h0);
    chk("addr_err_in_range_l2", 32'(b_aerr), 32'h0);
    set_wr(1, 13'd5200, 32'h99999999, 4'hF); set_rd(0, 13'd5200, 32'h0, 1); cycle();
    chk("addr_err_set_l1", 32'(a_aerr), 32'h1);
    chk("addr_err_set_l2", 32'(b_aerr), 32'h1);
    repeat (4) cycle();
    chk("addr_err_held_l1", 32'(a_aerr), 32'h1);
    chk("addr_err_held_l2", 32'(b_aerr), 32'h1);

    // Reset one cycle after an accepted read: the read is dropped, memory survives.
    set_rd(0, 13'h20, 32'h0, 0); cycle();
    reset = 1; cycle();
    chk("mid_reset_rvld_l1", 32'(a_s1_rvld), 32'h0);
    chk("mid_reset_rvld_l2", 32'(b_s1_rvld), 32'h0);
    chk("mid_reset_rdata_l1", a_s1_rdata, 32'h0);
    chk("mid_reset_addr_err", 32'(a_aerr), 32'h0);
    reset = 0;
    repeat (3) cycle();
    set_rd(0, 13'h10, 32'hDEADBEEF, 1); set_rd(1, 13'd5, 32'h11BB33DD, 1); cycle();
    set_rd(0, 13'd7, 32'h00000000, 1);  set_rd(1, 13'h20, 32'h12345678, 1); cycle();

    for (int i = 0; i < 30 && !queues_empty(); i++) cycle();
    repeat (3) cycle();
    for (int i = 0; i < 4; i++) chk($sformatf("drain ch%0d", i), 32'(exp_q[i].size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
